// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide into HI/LO.
// Ports: clk, reset (async, active-low), start, alucontrol[2:0] (011 mul, 100 div),
//   srca/srcb operands in; busy, done pulse, hi, lo, divzero out.
// Define MULDIV_SIGNED_EN for two's-complement operands (default unsigned).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_MULT = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t state, state_nx;

    // acc: mul = {partial product, remaining multiplier bits}
    //      div = {partial remainder, dividend shifting into quotient}
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opd;
    logic [CW-1:0]      cnt;

    logic is_mul, is_div, accept, dz, last;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign is_mul = (alucontrol == OP_MULT);
    assign is_div = (alucontrol == OP_DIV);
    assign accept = (state == IDLE) && start && (is_mul || is_div);
    assign dz     = (opd == '0);
    assign last   = (cnt == '0);

    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_nx;
    assign msum   = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd})
                           : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign mul_nx = {msum, acc[WIDTH-1:1]};

    // Trial subtract on the shifted remainder; bit WIDTH set means negative.
    logic [WIDTH:0]     dshf, dtry;
    logic               dbit;
    logic [2*WIDTH-1:0] div_nx;
    assign dshf   = acc[2*WIDTH-1:WIDTH-1];
    assign dtry   = dshf - {1'b0, opd};
    assign dbit   = ~dtry[WIDTH];
    assign div_nx = {(dbit ? dtry[WIDTH-1:0] : dshf[WIDTH-1:0]),
                     acc[WIDTH-2:0], dbit};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, dvd;

`ifdef MULDIV_SIGNED_EN
    logic neg_q, neg_r;
    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH-1:0]   quo_n, rem_n, dvd_n;

    assign mag_a  = srca[WIDTH-1] ? -srca : srca;
    assign mag_b  = srcb[WIDTH-1] ? -srcb : srcb;
    assign prod_n = -mul_nx;
    assign quo_n  = -div_nx[WIDTH-1:0];
    assign rem_n  = -div_nx[2*WIDTH-1:WIDTH];
    assign dvd_n  = -acc[WIDTH-1:0];
    assign prod   = neg_q ? prod_n : mul_nx;
    assign quo    = neg_q ? quo_n : div_nx[WIDTH-1:0];
    assign rem    = neg_r ? rem_n : div_nx[2*WIDTH-1:WIDTH];
    // Dividend magnitude is still intact on divide-by-zero; restore its sign.
    assign dvd    = neg_r ? dvd_n : acc[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= srca[WIDTH-1] ^ srcb[WIDTH-1];
            neg_r <= srca[WIDTH-1];
        end
    end
`else
    assign mag_a = srca;
    assign mag_b = srcb;
    assign prod  = mul_nx;
    assign quo   = div_nx[WIDTH-1:0];
    assign rem   = div_nx[2*WIDTH-1:WIDTH];
    assign dvd   = acc[WIDTH-1:0];
`endif

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_nx = is_mul ? MUL : DIV;
            end
            MUL: if (last) state_nx = FIN;
            DIV: if (dz || last) state_nx = FIN;
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            acc     <= '0;
            opd     <= '0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            divzero <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        opd     <= is_mul ? mag_a : mag_b;
                        acc     <= {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
                        cnt     <= CW'(WIDTH - 1);
                        divzero <= 1'b0;
                    end
                end
                MUL: begin
                    acc <= mul_nx;
                    if (last) begin
                        {hi, lo} <= prod;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (dz) begin
                        hi      <= dvd;
                        lo      <= '1;
                        divzero <= 1'b1;
                    end else begin
                        acc <= div_nx;
                        if (last) begin
                            hi <= rem;
                            lo <= quo;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
